// File: rtl/lcd_pkg.sv
// Shared LCD definitions: writer FSM state encoding, RGB565 colours, command codes.
package lcd_pkg;

   localparam int STATE_W = 6;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 6'b000001,
      ST_SETUP = 6'b000010,
      ST_SHIFT = 6'b000100,
      ST_HOLD  = 6'b001000,
      ST_DONE  = 6'b010000,
      ST_GAP   = 6'b100000
   } lcd_state_t;

   localparam logic [15:0] WHITE = 16'hFFFF;
   localparam logic [15:0] BLACK = 16'h0000;
   localparam logic [15:0] BROWN = 16'hBC40;
   localparam logic [15:0] RED   = 16'hF800;
   localparam logic [15:0] GREEN = 16'h07E0;
   localparam logic [15:0] BLUE  = 16'h001F;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   localparam int DC_BIT = 8;

endpackage

// File: rtl/lcd_bit_timer.sv
// Phase counter for the SPI writer: strobes phase_end every CLK_DIV cycles while run is high.
module lcd_bit_timer #(
   parameter int CLK_DIV = 2
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic run,
   output logic phase_end
);

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt;

   assign phase_end = run && (cnt == LAST);

   // Counter parks at zero when idle so every phase starts with a full CLK_DIV count.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt <= 8'd0;
      end else if (!run || phase_end) begin
         cnt <= 8'd0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/lcd_spi_writer.sv
// SPI mode-0 byte writer for the LCD: {dc, byte} in, CS/DC/SCLK/MOSI out, wr_done per byte.
// Optional LCD_SPI_CS_BURST_EN keeps CS low across back-to-back words.
module lcd_spi_writer
   import lcd_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       en_write,
   input  logic [8:0] data,
   output logic       wr_done,
   output logic       busy,
   output logic       lcd_cs_n,
   output logic       lcd_dc,
   output logic       lcd_sclk,
   output logic       lcd_mosi
);

   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

`ifdef LCD_SPI_CS_BURST_EN
   localparam logic CS_AFTER_BYTE = 1'b0;
`else
   localparam logic CS_AFTER_BYTE = 1'b1;
`endif

   lcd_state_t state, state_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] gap_cnt, gap_cnt_nxt;
   logic       cs_n_nxt, dc_nxt, sclk_nxt, mosi_nxt, wr_done_nxt, busy_nxt;
   logic       timer_run, phase_end;

   assign timer_run = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);

   lcd_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .run       (timer_run),
      .phase_end (phase_end)
   );

   // All outputs are computed from the next state so that they change on the same edge as the state.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= ST_IDLE;
         shreg    <= 8'd0;
         bit_cnt  <= 3'd0;
         gap_cnt  <= 8'd0;
         lcd_cs_n <= 1'b1;
         lcd_dc   <= 1'b0;
         lcd_sclk <= 1'b0;
         lcd_mosi <= 1'b0;
         wr_done  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         bit_cnt  <= bit_cnt_nxt;
         gap_cnt  <= gap_cnt_nxt;
         lcd_cs_n <= cs_n_nxt;
         lcd_dc   <= dc_nxt;
         lcd_sclk <= sclk_nxt;
         lcd_mosi <= mosi_nxt;
         wr_done  <= wr_done_nxt;
         busy     <= busy_nxt;
      end
   end

   // SCLK phase is tracked by lcd_sclk itself; MOSI advances only on the falling edge.
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      gap_cnt_nxt = gap_cnt;
      cs_n_nxt    = lcd_cs_n;
      dc_nxt      = lcd_dc;
      sclk_nxt    = lcd_sclk;
      mosi_nxt    = lcd_mosi;
      wr_done_nxt = 1'b0;

      case (state)
         ST_IDLE: begin
            cs_n_nxt = !en_write;
            if (en_write) begin
               shreg_nxt   = data[7:0];
               dc_nxt      = data[DC_BIT];
               mosi_nxt    = data[7];
               bit_cnt_nxt = 3'd7;
               state_nxt   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (phase_end) begin
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (phase_end) begin
               if (!lcd_sclk) begin
                  sclk_nxt = 1'b1;
               end else begin
                  sclk_nxt = 1'b0;
                  if (bit_cnt == 3'd0) begin
                     state_nxt = ST_HOLD;
                  end else begin
                     bit_cnt_nxt = bit_cnt - 3'd1;
                     shreg_nxt   = {shreg[6:0], 1'b0};
                     mosi_nxt    = shreg[6];
                  end
               end
            end
         end
         ST_HOLD: begin
            if (phase_end) begin
               state_nxt   = ST_DONE;
               wr_done_nxt = 1'b1;
               cs_n_nxt    = CS_AFTER_BYTE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               gap_cnt_nxt = 8'd0;
               state_nxt   = ST_IDLE;
            end else begin
               gap_cnt_nxt = gap_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cs_n_nxt  = 1'b1;
            sclk_nxt  = 1'b0;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

endmodule
